// File: rtl/mux_scan_ctrl.sv
// Sequencer for a 4:1 mux: steps sel 0..3, holds each code SETTLE_CYCLES, samples mux_out into a 4-bit word.
// Optional continuous-scan input `cont` is enabled by defining MUX_SCAN_CONT_EN.
module mux_scan_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
`ifdef MUX_SCAN_CONT_EN
    input  logic       cont,
`endif
    output logic       busy,
    output logic [1:0] sel,
    input  logic       mux_out,
    output logic [3:0] data,
    output logic       valid
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       shadow;
    logic             cont_now;

`ifdef MUX_SCAN_CONT_EN
    assign cont_now = cont;
`else
    assign cont_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            sel    <= '0;
            busy   <= 1'b0;
            data   <= '0;
            valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    sel   <= '0;
                    if (start) begin
                        state <= SETTLE;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SETTLE: begin
                    valid <= 1'b0;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (sel != 2'd3) begin
                            shadow[sel] <= mux_out;
                            sel         <= sel + 2'd1;
                        end else begin
                            data  <= {mux_out, shadow};
                            valid <= 1'b1;
                            // Continuous mode restarts at sel=0 without passing through DONE/IDLE
                            if (cont_now) begin
                                sel <= '0;
                            end else begin
                                state <= DONE;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    sel   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: stimulus queues expected words and due cycles, a negedge monitor checks each valid.
module tb_mux_scan_ctrl;

`ifdef MUX_SCAN_CONT_EN
    localparam int SC = 1;
`else
    localparam int SC = 2;
`endif

    typedef struct {
        logic [3:0] word;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic [1:0] sel;
    logic       mux_out;
    logic [3:0] data;
    logic       valid;
    logic [3:0] in_vec;
`ifdef MUX_SCAN_CONT_EN
    logic       cont;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mux_out = in_vec[sel];

    mux_scan_ctrl #(.SETTLE_CYCLES(SC), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
`ifdef MUX_SCAN_CONT_EN
        .cont    (cont),
`endif
        .busy    (busy),
        .sel     (sel),
        .mux_out (mux_out),
        .data    (data),
        .valid   (valid)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued expectation in value and cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: data=%b at cycle %0d, no scan pending", data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (data !== e.word || cyc != e.due) begin
                    failures++;
                    $display("FAIL scan_word: got data=%b at cycle %0d, expected %b at cycle %0d",
                             data, cyc, e.word, e.due);
                end
            end
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_sel"},   int'(sel),   0);
        check({tag, "_busy"},  int'(busy),  0);
        check({tag, "_valid"}, int'(valid), 0);
    endtask

    // Called at a negedge. Runs one single-shot scan; optional stray start pulse at step `poke`.
    task automatic scan(input logic [3:0] v, input logic [3:0] prev, input int poke);
        in_vec = v;
        start  = 1'b1;
        exp_q.push_back('{v, cyc + 1 + 4 * SC});
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4 * SC; i++) begin
            check("seq_sel",  int'(sel),   i / SC);
            check("seq_busy", int'(busy),  1);
            check("seq_data_hold", int'(data), int'(prev));
            start = (i == poke) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
        check("done_sel",  int'(sel),  3);
        check("done_busy", int'(busy), 1);
        @(negedge clk);
        check_idle("post_done");
        check("post_data", int'(data), int'(v));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int d1;
        int n;
        rst_n  = 1'b0;
        start  = 1'b1;
        in_vec = 4'b0000;
`ifdef MUX_SCAN_CONT_EN
        cont   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_idle("reset");
        check("reset_data", int'(data), 0);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle("idle_no_start");

`ifndef MUX_SCAN_CONT_EN
        // Basic scan, then data hold with a new pattern
        scan(4'b1010, 4'b0000, -1);
        repeat (2) @(negedge clk);
        scan(4'b0110, 4'b1010, -1);
        repeat (2) @(negedge clk);

        // Stray start during the scan must not queue a second scan
        scan(4'b1001, 4'b0110, 3);
        repeat (4 * SC + 4) @(negedge clk);
        check("no_requeue_busy", int'(busy), 0);

        // Held start: back-to-back scans with one IDLE cycle between them
        in_vec = 4'b1100;
        start  = 1'b1;
        d1 = cyc + 1 + 4 * SC;
        exp_q.push_back('{4'b1100, d1});
        exp_q.push_back('{4'b1100, d1 + 2 + 4 * SC});
        while (cyc < d1 + 1) @(negedge clk);
        check("gap_busy", int'(busy), 0);
        check("gap_sel",  int'(sel),  0);
        @(negedge clk);
        check("restart_busy", int'(busy), 1);
        start = 1'b0;
        while (cyc < d1 + 2 + 4 * SC + 3) @(negedge clk);
        check("held_end_busy", int'(busy), 0);

        // Reset mid-scan while sel==2, start held during reset
        in_vec = 4'b1010;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (sel != 2'd2 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("reach_sel2", int'(sel), 2);
        start = 1'b1;
        rst_n = 1'b0;
        #1;
        check_idle("mid_reset");
        check("mid_reset_data", int'(data), 0);
        repeat (3) @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (4 * SC + 4) @(negedge clk);
        check_idle("after_reset");
        check("after_reset_data", int'(data), 0);
        scan(4'b1111, 4'b0000, -1);
        repeat (3) @(negedge clk);
`else
        // Continuous mode: three back-to-back scans, cont dropped before the third final sample
        in_vec = 4'b0101;
        cont   = 1'b1;
        start  = 1'b1;
        d1 = cyc + 1 + 4 * SC;
        exp_q.push_back('{4'b0101, d1});
        exp_q.push_back('{4'b0101, d1 + 4 * SC});
        exp_q.push_back('{4'b0101, d1 + 8 * SC});
        @(negedge clk);
        start = 1'b0;
        while (cyc < d1 + 8 * SC) begin
            check("cont_busy", int'(busy), 1);
            if (cyc == d1 + 4 * SC) cont = 1'b0;
            @(negedge clk);
        end
        check("cont_done_sel", int'(sel), 3);
        @(negedge clk);
        check_idle("cont_end");
        check("cont_data", int'(data), 5);
        repeat (4 * SC + 3) @(negedge clk);
        check("cont_stays_idle", int'(busy), 0);
`endif

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
